// File: rtl/slice_pack_if.sv
// slice_pack_if: slice input and packed-word output bundle for slice_pack
interface slice_pack_if #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int NUM_SLICES = 4
);
    logic sync_in;
    logic valid_in;
    logic [INPUT_DATA_WIDTH-1:0] data_in;
    logic [INPUT_DATA_WIDTH*NUM_SLICES-1:0] data_out;
    logic valid_out;
    logic sync_out;
    modport master (output sync_in, valid_in, data_in, input data_out, valid_out, sync_out);
    modport slave (input sync_in, valid_in, data_in, output data_out, valid_out, sync_out);
endinterface

// File: rtl/slice_pack.sv
// slice_pack: gathers successive narrow slices into one wide word with sync-based alignment
module slice_pack #(
    parameter string ARCHITECTURE = "BEHAVIORAL",
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int NUM_SLICES = 4,
    parameter int MSB_FIRST = 1
) (
    input logic clk,
    input logic rst,
    slice_pack_if.slave bus
);
    localparam int W = INPUT_DATA_WIDTH;
    localparam int N = NUM_SLICES;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    if (ARCHITECTURE != "BEHAVIORAL") begin : g_bad_arch
        $error("slice_pack: unsupported ARCHITECTURE");
    end
    logic [CW-1:0] count, cnt_eff, slot;
    logic [W*N-1:0] asm_r, word;
    logic pending, pend_eff, last;
    // a sync in the same cycle as a slice restarts the word at that slice
    always_comb begin
        cnt_eff = bus.sync_in ? '0 : count;
        slot = MSB_FIRST != 0 ? CW'(N - 1) - cnt_eff : cnt_eff;
        word = bus.sync_in ? '0 : asm_r;
        word[int'(slot) * W +: W] = bus.data_in;
    end
    assign pend_eff = pending | bus.sync_in;
    assign last = cnt_eff == CW'(N - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            asm_r <= '0;
            pending <= 1'b0;
            bus.data_out <= '0;
            bus.valid_out <= 1'b0;
            bus.sync_out <= 1'b0;
        end else begin
            bus.valid_out <= 1'b0;
            bus.sync_out <= 1'b0;
            if (bus.valid_in && last) begin
                bus.data_out <= word;
                bus.valid_out <= 1'b1;
                bus.sync_out <= pend_eff;
                pending <= 1'b0;
                count <= '0;
                asm_r <= '0;
            end else if (bus.valid_in) begin
                asm_r <= word;
                count <= cnt_eff + 1'b1;
                pending <= pend_eff;
            end else if (bus.sync_in) begin
                asm_r <= '0;
                count <= '0;
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_slice_pack.sv
// tb_slice_pack: table, directed and random checks of three slice_pack configurations against a queue model
module tb_slice_pack;
    logic clk = 1'b0;
    logic rst = 1'b0, sync_in = 1'b0, valid_in = 1'b0;
    logic [7:0] data_in = '0;
    int checks = 0, fails = 0;
    always #5 clk = ~clk;

    slice_pack_if #(.INPUT_DATA_WIDTH(8), .NUM_SLICES(4)) i0 ();
    slice_pack_if #(.INPUT_DATA_WIDTH(8), .NUM_SLICES(4)) i1 ();
    slice_pack_if #(.INPUT_DATA_WIDTH(8), .NUM_SLICES(1)) i2 ();
    assign i0.sync_in = sync_in;
    assign i0.valid_in = valid_in;
    assign i0.data_in = data_in;
    assign i1.sync_in = sync_in;
    assign i1.valid_in = valid_in;
    assign i1.data_in = data_in;
    assign i2.sync_in = sync_in;
    assign i2.valid_in = valid_in;
    assign i2.data_in = data_in;

    slice_pack #(.INPUT_DATA_WIDTH(8), .NUM_SLICES(4), .MSB_FIRST(1)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
    slice_pack #(.INPUT_DATA_WIDTH(8), .NUM_SLICES(4), .MSB_FIRST(0)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
    slice_pack #(.INPUT_DATA_WIDTH(8), .NUM_SLICES(1), .MSB_FIRST(1)) u2 (.clk(clk), .rst(rst), .bus(i2.slave));

    logic [31:0] od [3];
    logic ov [3], os [3];
    assign od[0] = i0.data_out;
    assign od[1] = i1.data_out;
    assign od[2] = {24'h0, i2.data_out};
    assign ov[0] = i0.valid_out;
    assign ov[1] = i1.valid_out;
    assign ov[2] = i2.valid_out;
    assign os[0] = i0.sync_out;
    assign os[1] = i1.sync_out;
    assign os[2] = i2.sync_out;

    // reference model: accepted slices collected in a queue, word built when the queue holds N
    logic [7:0] mq [3][$];
    bit mpend [3];
    logic [31:0] mdata [3];
    bit mv [3], ms [3];
    int mn [3] = '{4, 4, 1};
    bit mmsb [3] = '{1'b1, 1'b0, 1'b1};

    function automatic logic [31:0] assemble(int d);
        logic [31:0] w = '0;
        for (int k = 0; k < mn[d]; k++) begin
            int pos = mmsb[d] ? mn[d] - 1 - k : k;
            w[pos*8 +: 8] = mq[d][k];
        end
        return w;
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            mv[d] = 0;
            ms[d] = 0;
            if (rst) begin
                mq[d].delete();
                mpend[d] = 0;
                mdata[d] = '0;
            end else begin
                if (sync_in) begin
                    mq[d].delete();
                    mpend[d] = 1;
                end
                if (valid_in) mq[d].push_back(data_in);
                if (mq[d].size() == mn[d]) begin
                    mdata[d] = assemble(d);
                    mv[d] = 1;
                    ms[d] = mpend[d];
                    mpend[d] = 0;
                    mq[d].delete();
                end
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(logic r, logic s, logic v, logic [7:0] d);
        rst = r;
        sync_in = s;
        valid_in = v;
        data_in = d;
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model data_out dut%0d", k), od[k], mdata[k]);
            chk($sformatf("model valid_out dut%0d", k), 32'(ov[k]), 32'(mv[k]));
            chk($sformatf("model sync_out dut%0d", k), 32'(os[k]), 32'(ms[k]));
        end
    endtask

    typedef struct {
        logic r, s, v;
        logic [7:0] d;
        logic [31:0] edata;
        logic ev, es;
    } vec_t;

    initial begin
        vec_t tbl [$];
        tbl = '{
            '{1, 0, 1, 8'hAA, 32'h0, 0, 0},
            '{1, 0, 1, 8'hAA, 32'h0, 0, 0},
            '{1, 0, 1, 8'hAA, 32'h0, 0, 0},
            '{0, 1, 0, 8'h00, 32'h0, 0, 0},
            '{0, 0, 1, 8'h11, 32'h0, 0, 0},
            '{0, 0, 1, 8'h22, 32'h0, 0, 0},
            '{0, 0, 1, 8'h33, 32'h0, 0, 0},
            '{0, 0, 1, 8'h44, 32'h11223344, 1, 1},
            '{0, 0, 1, 8'h55, 32'h11223344, 0, 0},
            '{0, 0, 1, 8'h66, 32'h11223344, 0, 0},
            '{0, 0, 1, 8'h77, 32'h11223344, 0, 0},
            '{0, 0, 1, 8'h88, 32'h55667788, 1, 0},
            '{0, 0, 1, 8'hA1, 32'h55667788, 0, 0},
            '{0, 0, 1, 8'hA2, 32'h55667788, 0, 0},
            '{0, 1, 1, 8'hB0, 32'h55667788, 0, 0},
            '{0, 0, 1, 8'hB1, 32'h55667788, 0, 0},
            '{0, 0, 1, 8'hB2, 32'h55667788, 0, 0},
            '{0, 0, 1, 8'hB3, 32'hB0B1B2B3, 1, 1},
            '{0, 0, 1, 8'h10, 32'hB0B1B2B3, 0, 0},
            '{0, 0, 1, 8'h20, 32'hB0B1B2B3, 0, 0},
            '{1, 0, 0, 8'h00, 32'h0, 0, 0},
            '{0, 0, 1, 8'h30, 32'h0, 0, 0},
            '{0, 0, 1, 8'h40, 32'h0, 0, 0},
            '{0, 0, 1, 8'h50, 32'h0, 0, 0},
            '{0, 0, 1, 8'h60, 32'h30405060, 1, 0},
            '{0, 0, 0, 8'h00, 32'h30405060, 0, 0}
        };
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].d);
            chk($sformatf("table %0d data_out", i), od[0], tbl[i].edata);
            chk($sformatf("table %0d valid_out", i), 32'(ov[0]), 32'(tbl[i].ev));
            chk($sformatf("table %0d sync_out", i), 32'(os[0]), 32'(tbl[i].es));
        end
        // LSB-first word with two idle cycles between slices; data_out holds across gaps
        for (int k = 1; k <= 4; k++) begin
            cyc(0, 0, 1, 8'(k));
            if (k < 4) begin
                chk("lsb partial valid_out", 32'(ov[1]), 32'h0);
                for (int g = 0; g < 2; g++) begin
                    cyc(0, 0, 0, 8'h00);
                    chk("lsb gap data_out", od[1], 32'h60504030);
                    chk("lsb gap valid_out", 32'(ov[1]), 32'h0);
                end
            end
        end
        chk("lsb word data_out", od[1], 32'h04030201);
        chk("lsb word valid_out", 32'(ov[1]), 32'h1);
        // single-slice words complete on every accepted slice
        cyc(0, 0, 1, 8'h7E);
        chk("n1 first data_out", od[2], 32'h7E);
        chk("n1 first valid_out", 32'(ov[2]), 32'h1);
        cyc(0, 0, 1, 8'h81);
        chk("n1 second data_out", od[2], 32'h81);
        chk("n1 second valid_out", 32'(ov[2]), 32'h1);
        cyc(0, 1, 1, 8'h5C);
        chk("n1 sync data_out", od[2], 32'h5C);
        chk("n1 sync sync_out", 32'(os[2]), 32'h1);
        cyc(0, 0, 0, 8'h00);
        chk("n1 idle valid_out", 32'(ov[2]), 32'h0);
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 3) != 0, 8'($urandom));
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
